// File: rtl/ddr_axi_arbiter.sv
// Two-client round-robin arbiter onto the MIG AXI4 slave port.
// Only one transaction is in flight at a time, so IDs are informational.
module ddr_axi_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_W      = 28,
  parameter int DATA_W      = 128
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic [1:0]            c_cmd_valid,
  output logic [1:0]            c_cmd_ready,
  input  logic [1:0]            c_cmd_write,
  input  logic [2*ADDR_W-1:0]   c_cmd_addr,
  input  logic [15:0]           c_cmd_len,
  input  logic [2*DATA_W-1:0]   c_wdata,
  input  logic [DATA_W/4-1:0]   c_wstrb,
  input  logic [1:0]            c_wvalid,
  output logic [1:0]            c_wready,
  output logic [DATA_W-1:0]     c_rdata,
  output logic [1:0]            c_rvalid,
  output logic                  c_rlast,
  input  logic [1:0]            c_rready,
  output logic [1:0]            c_done,
  output logic [1:0]            c_resp,
  output logic [3:0]            m_axi_awid,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [3:0]            m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [3:0]            m_axi_arid,
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [3:0]            m_axi_rid,
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              rr_q, rr_d;
  logic              grant_q, grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [1:0]        resp_q, resp_d;

  logic              win, accept, w_hs, r_hs, done;
  logic [1:0]        grant_oh, done_resp;
  logic [ADDR_W-1:0] win_addr;

  // IDs and the ignored low address nibble are deliberately unused.
  logic unused_ok;
  assign unused_ok = ^{m_axi_bid, m_axi_rid, c_cmd_addr[3:0], c_cmd_addr[ADDR_W+3:ADDR_W]};

  function automatic logic [1:0] worst_resp(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign win      = (c_cmd_valid == 2'b11) ? rr_q : c_cmd_valid[1];
  assign accept   = (state_q == S_IDLE) && (c_cmd_valid != 2'b00);
  assign win_addr = win ? c_cmd_addr[2*ADDR_W-1:ADDR_W] : c_cmd_addr[ADDR_W-1:0];
  assign grant_oh = grant_q ? 2'b10 : 2'b01;

  assign w_hs      = (state_q == S_W) && m_axi_wvalid && m_axi_wready;
  assign r_hs      = (state_q == S_R) && m_axi_rvalid && m_axi_rready;
  assign done      = ((state_q == S_B) && m_axi_bvalid) || (r_hs && m_axi_rlast);
  assign done_resp = (state_q == S_B) ? m_axi_bresp : worst_resp(resp_q, m_axi_rresp);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    write_d = write_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    resp_d  = resp_q;
    case (state_q)
      S_IDLE: if (accept) begin
        grant_d = win;
        write_d = win ? c_cmd_write[1] : c_cmd_write[0];
        addr_d  = {win_addr[ADDR_W-1:4], 4'b0000};
        len_d   = win ? c_cmd_len[15:8] : c_cmd_len[7:0];
        cnt_d   = 8'd0;
        resp_d  = 2'b00;
        state_d = (win ? c_cmd_write[1] : c_cmd_write[0]) ? S_AW : S_AR;
      end
      S_AW: if (m_axi_awready) state_d = S_W;
      S_W: if (w_hs) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == len_q) state_d = S_B;
      end
      S_B: if (m_axi_bvalid) begin
        resp_d  = m_axi_bresp;
        rr_d    = ~grant_q;
        state_d = S_IDLE;
      end
      S_AR: if (m_axi_arready) state_d = S_R;
      S_R: if (r_hs) begin
        resp_d = worst_resp(resp_q, m_axi_rresp);
        if (m_axi_rlast) begin
          rr_d    = ~grant_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk) begin
    if (axi_reset) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      grant_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      len_q   <= 8'd0;
      cnt_q   <= 8'd0;
      resp_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
    end
  end

  assign c_cmd_ready = accept ? (win ? 2'b10 : 2'b01) : 2'b00;

  assign m_axi_awid    = {3'b000, grant_q};
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'b100;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = (state_q == S_AW) && write_q;

  assign m_axi_arid    = {3'b000, grant_q};
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'b100;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = 4'b0011;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;
  assign m_axi_arvalid = (state_q == S_AR);

  // Data channels pass straight through so bursts can stream one beat per cycle.
  assign m_axi_wdata  = grant_q ? c_wdata[2*DATA_W-1:DATA_W] : c_wdata[DATA_W-1:0];
  assign m_axi_wstrb  = grant_q ? c_wstrb[DATA_W/4-1:DATA_W/8] : c_wstrb[DATA_W/8-1:0];
  assign m_axi_wvalid = (state_q == S_W) && c_wvalid[grant_q];
  assign m_axi_wlast  = (state_q == S_W) && (cnt_q == len_q);
  assign c_wready     = ((state_q == S_W) && m_axi_wready) ? grant_oh : 2'b00;

  assign m_axi_bready = (state_q == S_B);

  assign m_axi_rready = (state_q == S_R) && c_rready[grant_q];
  assign c_rvalid     = ((state_q == S_R) && m_axi_rvalid) ? grant_oh : 2'b00;
  assign c_rlast      = (state_q == S_R) && m_axi_rlast;
  assign c_rdata      = m_axi_rdata;

  assign c_done = done ? grant_oh : 2'b00;
  assign c_resp = done ? done_resp : resp_q;

endmodule

// File: tb/tb_ddr_axi_arbiter.sv
// Directed bench for ddr_axi_arbiter; the bench plays both clients and the MIG slave.
module tb_ddr_axi_arbiter;

  logic         axi_clk = 1'b0;
  logic         axi_reset;
  logic [1:0]   c_cmd_valid, c_cmd_ready, c_cmd_write;
  logic [55:0]  c_cmd_addr;
  logic [15:0]  c_cmd_len;
  logic [255:0] c_wdata;
  logic [31:0]  c_wstrb;
  logic [1:0]   c_wvalid, c_wready;
  logic [127:0] c_rdata;
  logic [1:0]   c_rvalid;
  logic         c_rlast;
  logic [1:0]   c_rready, c_done, c_resp;
  logic [3:0]   awid, awcache, awqos, arid, arcache, arqos, bid, rid;
  logic [27:0]  awaddr, araddr;
  logic [7:0]   awlen, arlen;
  logic [2:0]   awsize, awprot, arsize, arprot;
  logic [1:0]   awburst, arburst, bresp, rresp;
  logic         awlock, awvalid, awready, arlock, arvalid, arready;
  logic [127:0] wdata, rdata;
  logic [15:0]  wstrb;
  logic         wlast, wvalid, wready, bvalid, bready, rlast, rvalid, rready;

  logic [127:0] mem [0:255];
  int n_chk = 0;
  int n_pass = 0;

  always #5 axi_clk = ~axi_clk;

  ddr_axi_arbiter dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .c_cmd_valid(c_cmd_valid), .c_cmd_ready(c_cmd_ready), .c_cmd_write(c_cmd_write),
    .c_cmd_addr(c_cmd_addr), .c_cmd_len(c_cmd_len),
    .c_wdata(c_wdata), .c_wstrb(c_wstrb), .c_wvalid(c_wvalid), .c_wready(c_wready),
    .c_rdata(c_rdata), .c_rvalid(c_rvalid), .c_rlast(c_rlast), .c_rready(c_rready),
    .c_done(c_done), .c_resp(c_resp),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  function automatic logic [7:0] idx(input logic [27:0] a, input int b);
    return a[11:4] + 8'(b);
  endfunction

  function automatic logic [1:0] oh(input int cl);
    return (cl == 1) ? 2'b10 : 2'b01;
  endfunction

  task automatic chk_quiet(input string tag);
    chk(tag, 128'({c_cmd_ready, c_wready, c_rvalid, c_done, c_resp, awvalid, arvalid,
                   wvalid, wlast, bready, rready}), 128'd0);
  endtask

  task automatic clear_inputs();
    c_cmd_valid = '0; c_cmd_write = '0; c_cmd_addr = '0; c_cmd_len = '0;
    c_wdata = '0; c_wstrb = '0; c_wvalid = '0; c_rready = '0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
  endtask

  task automatic issue(input logic [1:0] req, input int cl, input logic wr,
                       input logic [27:0] addr, input logic [7:0] len);
    @(negedge axi_clk);
    c_cmd_valid = req; c_cmd_write = {wr, wr}; c_cmd_addr = {addr, addr}; c_cmd_len = {len, len};
    #1 chk("cmd_ready", 128'(c_cmd_ready), 128'(oh(cl)));
    @(negedge axi_clk);
    c_cmd_valid = '0;
  endtask

  task automatic do_write(input int cl, input logic [27:0] addr, input logic [7:0] len,
                          input logic [127:0] base, input logic [1:0] br,
                          input logic [27:0] exp_addr, input int abort_beat);
    issue(oh(cl), cl, 1'b1, addr, len);
    #1;
    chk("awvalid", 128'(awvalid), 128'd1);
    chk("awaddr", 128'(awaddr), 128'(exp_addr));
    chk("awlen", 128'(awlen), 128'(len));
    chk("awid", 128'(awid), 128'(cl));
    chk("awfix", 128'({awsize, awburst, awcache}), 128'({3'b100, 2'b01, 4'b0011}));
    awready = 1;
    @(negedge axi_clk);
    awready = 0;
    for (int b = 0; b <= int'(len); b++) begin
      c_wvalid = oh(cl); c_wdata = {2{base + 128'(b)}}; c_wstrb = '1; wready = 1;
      #1;
      chk("wvalid", 128'(wvalid), 128'd1);
      chk("c_wready", 128'(c_wready), 128'(oh(cl)));
      chk("wlast", 128'(wlast), 128'(b == int'(len)));
      chk("wdata", wdata, base + 128'(b));
      if (b == abort_beat) begin
        axi_reset = 1;
        chk("abort_done", 128'(c_done), 128'd0);
        @(negedge axi_clk);
        clear_inputs();
        axi_reset = 0;
        #1 chk_quiet("post_abort");
        return;
      end
      mem[idx(addr, b)] = base + 128'(b);
      @(negedge axi_clk);
    end
    c_wvalid = '0; wready = 0;
    #1;
    chk("bready", 128'(bready), 128'd1);
    chk("b_early_done", 128'(c_done), 128'd0);
    bvalid = 1; bresp = br;
    #1;
    chk("w_done", 128'(c_done), 128'(oh(cl)));
    chk("w_resp", 128'(c_resp), 128'(br));
    @(negedge axi_clk);
    bvalid = 0; bresp = '0;
    #1 chk("w_done_pulse", 128'(c_done), 128'd0);
  endtask

  task automatic do_read(input logic [1:0] req, input int cl, input logic [27:0] addr,
                         input logic [7:0] len, input int err_beat, input logic [1:0] err,
                         input bit bp, input logic [1:0] exp_resp);
    int b;
    int cyc;
    issue(req, cl, 1'b0, addr, len);
    #1;
    chk("arvalid", 128'(arvalid), 128'd1);
    chk("araddr", 128'(araddr), 128'(addr));
    chk("arlen", 128'(arlen), 128'(len));
    chk("arid", 128'(arid), 128'(cl));
    arready = 1;
    @(negedge axi_clk);
    arready = 0;
    b = 0; cyc = 0;
    while (b <= int'(len) && cyc < 100) begin
      rvalid   = bp ? (cyc % 3 != 2) : 1'b1;
      c_rready = (!bp || cyc % 2 == 0) ? oh(cl) : 2'b00;
      rdata    = mem[idx(addr, b)];
      rlast    = (b == int'(len));
      rresp    = (b == err_beat) ? err : 2'b00;
      #1;
      chk("rready_pass", 128'(rready), 128'(c_rready[cl]));
      chk("c_rvalid", 128'(c_rvalid), rvalid ? 128'(oh(cl)) : 128'd0);
      if (rvalid && c_rready[cl]) begin
        chk("rdata", c_rdata, mem[idx(addr, b)]);
        chk("c_rlast", 128'(c_rlast), 128'(b == int'(len)));
        chk("r_done", 128'(c_done), (b == int'(len)) ? 128'(oh(cl)) : 128'd0);
        if (b == int'(len)) chk("r_resp", 128'(c_resp), 128'(exp_resp));
        b++;
      end else begin
        chk("r_stall_done", 128'(c_done), 128'd0);
      end
      @(negedge axi_clk);
      cyc++;
    end
    if (b <= int'(len)) chk("r_timeout", 128'(b), 128'(int'(len) + 1));
    rvalid = 0; rlast = 0; rresp = '0; c_rready = '0;
    #1 chk("r_done_pulse", 128'(c_done), 128'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 128'hA500 + 128'(i);
    clear_inputs();
    axi_reset = 1;
    repeat (2) @(negedge axi_clk);
    #1 chk_quiet("reset_outputs");
    axi_reset = 0;

    // simultaneous requests: rr starts at 0, then alternates
    do_read(2'b11, 0, 28'h0000000, 8'd3, -1, 2'b00, 1'b0, 2'b00);
    do_read(2'b11, 1, 28'h0000040, 8'd1, -1, 2'b00, 1'b0, 2'b00);
    do_read(2'b11, 0, 28'h0000080, 8'd0, -1, 2'b00, 1'b0, 2'b00);

    do_write(0, 28'h0000100, 8'd3, 128'd1, 2'b00, 28'h0000100, -1);
    do_read(2'b01, 0, 28'h0000100, 8'd3, -1, 2'b00, 1'b0, 2'b00);

    do_read(2'b10, 1, 28'h0000200, 8'd7, -1, 2'b00, 1'b1, 2'b00);

    do_write(0, 28'h000010F, 8'd0, 128'h77, 2'b00, 28'h0000100, -1);

    do_read(2'b01, 0, 28'h0000300, 8'd3, 1, 2'b10, 1'b0, 2'b10);
    do_write(1, 28'h0000400, 8'd1, 128'h50, 2'b11, 28'h0000400, -1);

    do_write(0, 28'h0000500, 8'd7, 128'h90, 2'b00, 28'h0000500, 1);
    do_read(2'b10, 1, 28'h0000500, 8'd1, -1, 2'b00, 1'b0, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
